// File: rtl/neuron_phase_ctrl.sv
// Phase sequencer for one ReLU neuron: steps the {FP,BP} mode code through
// forward/backward setup and compute phases and supplies backward operands.
module neuron_phase_ctrl #(
    parameter int N         = 6,
    parameter int BITS      = 16,
    parameter int FP_CYCLES = N / 2 + 4,
    parameter int BP_CYCLES = N + 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_fwd,
    input  logic            start_bwd,
    input  logic            use_target,
    input  logic [BITS-1:0] target,
    input  logic [BITS-1:0] dz_ext,
    input  logic [BITS-1:0] w_ext,
    input  logic [BITS-1:0] lr_in,
    input  logic [BITS-1:0] y,
    output logic            FP,
    output logic            BP,
    output logic [BITS-1:0] dZ_out,
    output logic [BITS-1:0] W_out,
    output logic [BITS-1:0] lr_out,
    output logic [BITS-1:0] y_out,
    output logic            busy,
    output logic            fwd_done,
    output logic            bwd_done,
    output logic            req_drop
);
    localparam int MAXC = (FP_CYCLES > BP_CYCLES) ? FP_CYCLES : BP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, FSETUP, FWD, BSETUP, BWD} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            fp_q, bp_q, busy_q, fwd_done_q, bwd_done_q, req_drop_q;
    logic [BITS-1:0] dz_q, w_q, lr_q, y_q;

    // MSE gradient in BITS+1 bits, clamped back into the signed BITS range
    logic [BITS:0]   diff;
    logic [BITS-1:0] grad_d;
    always_comb begin
        diff = {y_q[BITS-1], y_q} - {target[BITS-1], target};
        if (diff[BITS] != diff[BITS-1])
            grad_d = diff[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        else
            grad_d = diff[BITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fp_q       <= 1'b0;
            bp_q       <= 1'b0;
            busy_q     <= 1'b0;
            fwd_done_q <= 1'b0;
            bwd_done_q <= 1'b0;
            req_drop_q <= 1'b0;
            dz_q       <= '0;
            w_q        <= '0;
            lr_q       <= '0;
            y_q        <= '0;
        end else begin
            fwd_done_q <= 1'b0;
            bwd_done_q <= 1'b0;
            req_drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start_fwd) begin
                        // forward wins a simultaneous request
                        state_q    <= FSETUP;
                        fp_q       <= 1'b0;
                        bp_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        req_drop_q <= start_bwd;
                    end else if (start_bwd) begin
                        state_q <= BSETUP;
                        fp_q    <= 1'b1;
                        bp_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        w_q     <= w_ext;
                        lr_q    <= lr_in;
                        dz_q    <= use_target ? grad_d : dz_ext;
                    end
                end
                FSETUP: begin
                    state_q    <= FWD;
                    cnt_q      <= CW'(FP_CYCLES);
                    fp_q       <= 1'b1;
                    bp_q       <= 1'b0;
                    req_drop_q <= start_fwd | start_bwd;
                end
                FWD: begin
                    req_drop_q <= start_fwd | start_bwd;
                    if (cnt_q == CW'(1)) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        fp_q       <= 1'b0;
                        bp_q       <= 1'b0;
                        busy_q     <= 1'b0;
                        fwd_done_q <= 1'b1;
                        y_q        <= y;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                BSETUP: begin
                    state_q    <= BWD;
                    cnt_q      <= CW'(BP_CYCLES);
                    fp_q       <= 1'b0;
                    bp_q       <= 1'b1;
                    req_drop_q <= start_fwd | start_bwd;
                end
                BWD: begin
                    req_drop_q <= start_fwd | start_bwd;
                    if (cnt_q == CW'(1)) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        fp_q       <= 1'b0;
                        bp_q       <= 1'b0;
                        busy_q     <= 1'b0;
                        bwd_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    fp_q    <= 1'b0;
                    bp_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign FP       = fp_q;
    assign BP       = bp_q;
    assign busy     = busy_q;
    assign fwd_done = fwd_done_q;
    assign bwd_done = bwd_done_q;
    assign req_drop = req_drop_q;
    assign dZ_out   = dz_q;
    assign W_out    = w_q;
    assign lr_out   = lr_q;
    assign y_out    = y_q;
endmodule
